serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first) with start/busy/done handshake.
// Define SERIAL_SUB_BIN_EN to add the bin port that seeds the borrow flop for chained words.
`timescale 1ns/1ps
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BIN_EN
    input  logic             bin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sd_r;
    logic [CW-1:0]    cnt_r;
    logic             br_r;
    logic             d_s;
    logic             br_s;
    logic             last_s;
    logic             seed_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // Full-subtractor cell on the current operand LSBs plus last-bit detect
    always_comb begin
        d_s    = fs_diff(sa_r[0], sb_r[0], br_r);
        br_s   = fs_borrow(sa_r[0], sb_r[0], br_r);
        last_s = (cnt_r == CW'(WIDTH - 1));
    end

    // Borrow seed taken on the accepting edge
    always_comb begin
        seed_s = 1'b0;
`ifdef SERIAL_SUB_BIN_EN
        seed_s = bin;
`else
        seed_s = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state register
    always_comb begin
        busy = (state_r == RUN);
        done = (state_r == DONE);
    end

    // Operand/result shift registers, bit counter, borrow flop and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_r   <= '0;
            sb_r   <= '0;
            sd_r   <= '0;
            cnt_r  <= '0;
            br_r   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sa_r  <= a;
                        sb_r  <= b;
                        sd_r  <= '0;
                        cnt_r <= '0;
                        br_r  <= seed_s;
                    end
                end
                RUN: begin
                    sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
                    sd_r  <= {d_s, sd_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CW'(1);
                    br_r  <= br_s;
                    // Publish the result including the bit being processed now
                    if (last_s) begin
                        diff   <= {d_s, sd_r[WIDTH-1:1]};
                        borrow <= br_s;
                    end
                end
                default: begin
                    sa_r <= sa_r;
                end
            endcase
        end
    end

endmodule
